csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR register file and trap-state holder for the RV32 pipeline.
- Answers the EX-stage CSR request interface (address, read/write strobes and data), tracks interrupt sources, and raises `interrupt_pending`/`interrupt_cause` to EX.
- Captures trap entry and return events (interrupt, ECALL, EBREAK, MRET) reported by EX. Exports `mtvec`/`mepc` for redirect.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
csr_addr  in  12  CSR address from EX
csr_read_enable  in  1  CSR instruction in EX (read request)
csr_write_enable  in  1  commit write this cycle
csr_write_data  in  32  new CSR value
csr_read_data  out  32  current CSR value (combinational)
csr_valid  out  1  address implemented and read requested
pc_ex  in  32  PC of instruction in EX (trap mepc source)
interrupt_taken  in  1  EX accepted pending interrupt
ecall_exception  in  1  ECALL executed
ebreak_exception  in  1  EBREAK executed
mret_instruction  in  1  MRET executed
instr_retired  in  1  one instruction retired this cycle
ext_irq  in  1  external interrupt level
timer_irq  in  1  timer interrupt level
sw_irq  in  1  software interrupt level
interrupt_pending  out  1  enabled interrupt waiting
interrupt_cause  out  32  mcause value for pending interrupt
mtvec  out  32  trap vector base
mepc  out  32  exception PC

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - mstatus = 32'h0000_1800 (MPP = 11, MIE = MPIE = 0).
  - mtvec = MTVEC_RESET with [1:0] = 0.
  - mie, mscratch, mepc, mcause, irq flops, all counters = 0.
  - interrupt_pending = 0.
  - interrupt_cause = 0.
- Implemented CSRs:
  - mstatus 0x300 (writable bits 3, 7 only).
  - misa 0x301, RO, 32'h4000_0100.
  - mie 0x304 (bits 3, 7, 11 writable).
  - mtvec 0x305 ([1:0] forced 0).
  - mscratch 0x340.
  - mepc 0x341 ([1:0] forced 0).
  - mcause 0x342.
  - mip 0x344, RO.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82, RO aliases.
  - mhartid 0xF14, RO.
- Read path:
  - Zero-latency combinational.
  - csr_valid = csr_read_enable && implemented address.
  - Otherwise csr_read_data = 0 and csr_valid = 0.
- Write path:
  - Takes effect at the next rising edge when csr_write_enable = 1.
  - Writes to RO or unimplemented addresses are silently dropped.
- Interrupt sources:
  - ext_irq, timer_irq, sw_irq are registered once into mip bits 11, 7, 3.
  - interrupt_pending = mstatus.MIE && |(mip & mie), combinational from registers.
- Interrupt priority and cause (same cycle):
  - MEI → 32'h8000_000B.
  - MSI → 32'h8000_0003.
  - MTI → 32'h8000_0007.
  - interrupt_cause = 0 when nothing is pending.
- Trap entry (edge where interrupt_taken, ecall_exception or ebreak_exception = 1):
  - mepc <= pc_ex & ~3.
  - mcause <= interrupt_cause / 11 / 3 respectively.
  - MPIE <= MIE; MIE <= 0.
  - Since MIE is cleared, interrupt_pending drops the cycle after entry.
- MRET: MIE <= MPIE, MPIE <= 1, mepc unchanged.
- Simultaneous events:
  - Event priority: interrupt_taken > ecall > ebreak > mret. Only the highest is applied.
  - A trap or MRET update of mstatus/mepc/mcause overrides a csr_write to the same register in that cycle.
  - Writes to other CSRs still commit.
- Counters: 64-bit, wrap from 2^64−1 to 0.
  - mcycle increments every cycle.
  - minstret increments when instr_retired = 1.
  - A CSR write to either 32-bit half replaces that half.
  - The increment is suppressed for that counter on that edge; the other half holds.
- rst asserted mid-operation restores all reset values immediately, including counters and pending state.

Optional Feature:
- ZICNTR_EN defined:
  - Counters and their aliases are implemented as above.
- ZICNTR_EN undefined:
  - No counter flops.
  - Counter addresses read as unimplemented (csr_valid = 0, data 0); writes are dropped.
  - instr_retired is ignored.

Decomposition:
- Shared package csr_defines holds:
  - CSR address localparams.
  - mstatus/mip/mie bit indices (MIE = 3, MPIE = 7, MSIP = 3, MTIP = 7, MEIP = 11).
  - Cause codes (ECALL_M = 11, BREAKPOINT = 3, interrupt causes).
  - misa constant.
- One natural sub-module, csr_counter64:
  - 64-bit counter with increment enable, low/high write strobes and write data.
  - Instantiated twice (mcycle, minstret) under ZICNTR_EN.

Test Plan:
- Reset, then read 0x300/0x301/0xF14 → 0x1800 / 0x40000100 / HART_ID, csr_valid = 1; read 0x7C0 → data 0, csr_valid = 0.
- Write mtvec = 0x0000_0103 → readback and mtvec port = 0x0000_0100; write misa = 0 → still 0x40000100.
- Set mie = 0x800, mstatus = 0x8, pulse ext_irq → interrupt_pending = 1 one cycle later, cause = 0x8000000B; assert interrupt_taken with pc_ex = 0x200 → mepc = 0x200, MIE = 0, MPIE = 1, pending drops.
- ECALL at pc_ex = 0x104, then MRET → mcause = 11, mepc = 0x104, MIE restored to 1; ECALL and csr_write to mepc = 0x999 in the same cycle → mepc = 0x104.
- ext_irq + timer_irq + sw_irq all enabled and asserted → cause 0x8000000B; drop ext → cause 0x80000003.
- With ZICNTR_EN, write mcycle = 0xFFFF_FFFF and mcycleh = 0xFFFF_FFFF, wait 2 cycles → mcycle = 0, mcycleh = 0 (wrap); three instr_retired pulses → minstret = 3. Without ZICNTR_EN, reading 0xB00 → csr_valid = 0.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, mstatus/mip/mie
// bit positions, trap cause codes, the misa constant and the trap event encoding.
package csr_defines;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  // Constant fields and masks
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP = 11 (M-mode only)
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;  // RV32I

  // Cause codes
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_MSI        = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI        = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI        = 32'h8000_000B;

  // Trap/return event applied on an edge; only one is applied at a time
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_IRQ    = 3'd1,
    EV_ECALL  = 3'd2,
    EV_EBREAK = 3'd3,
    EV_MRET   = 3'd4
  } trap_event_e;

  // Fixed-priority interrupt cause: MEI, then MSI, then MTI
  function automatic logic [31:0] irq_cause(input logic [31:0] active);
    if (active[MIP_MEIP])      irq_cause = CAUSE_MEI;
    else if (active[MIP_MSIP]) irq_cause = CAUSE_MSI;
    else if (active[MIP_MTIP]) irq_cause = CAUSE_MTI;
    else                       irq_cause = 32'd0;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half write strobes. A write to either
// half replaces that half, holds the other, and suppresses the increment.
module csr_counter64
  import csr_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  // Next count: half write wins over increment; increment wraps naturally
  always_comb begin
    count_d = count_q;
    if (wr_lo_i)      count_d = {count_q[63:32], wdata_i};
    else if (wr_hi_i) count_d = {wdata_i, count_q[31:0]};
    else if (inc_i)   count_d = count_q + 64'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 64'd0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap-state holder for the RV32 pipeline.
// Optional counters (mcycle/minstret and user aliases) are built when ZICNTR_EN
// is defined; otherwise those addresses read as unimplemented.
// Read handshake: csr_read_data/csr_valid are combinational from csr_addr and
// csr_read_enable; a write commits on the rising edge where csr_write_enable=1.
module csr_file
  import csr_defines::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic        csr_read_enable,
  input  logic        csr_write_enable,
  input  logic [31:0] csr_write_data,
  output logic [31:0] csr_read_data,
  output logic        csr_valid,
  input  logic [31:0] pc_ex,
  input  logic        interrupt_taken,
  input  logic        ecall_exception,
  input  logic        ebreak_exception,
  input  logic        mret_instruction,
  input  logic        instr_retired,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  output logic        interrupt_pending,
  output logic [31:0] interrupt_cause,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mstatus_rd;
  trap_event_e ev;

  assign mstatus_rd = MSTATUS_FIXED
                    | (32'(st_mpie_q) << MSTATUS_MPIE)
                    | (32'(st_mie_q) << MSTATUS_MIE);

  // Pending interrupt and its cause, purely from registered state
  always_comb begin
    interrupt_pending = st_mie_q && (|(mip_q & mie_q));
    interrupt_cause   = interrupt_pending ? irq_cause(mip_q & mie_q) : 32'd0;
  end

  // Select the single trap/return event applied this edge
  always_comb begin
    ev = EV_NONE;
    if (interrupt_taken)       ev = EV_IRQ;
    else if (ecall_exception)  ev = EV_ECALL;
    else if (ebreak_exception) ev = EV_EBREAK;
    else if (mret_instruction) ev = EV_MRET;
  end

  // Next-state for trap state and writable CSRs; trap/MRET beat a CSR write
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    mip_d           = 32'd0;
    mip_d[MIP_MEIP] = ext_irq;
    mip_d[MIP_MTIP] = timer_irq;
    mip_d[MIP_MSIP] = sw_irq;

    if (csr_write_enable) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          st_mie_d  = csr_write_data[MSTATUS_MIE];
          st_mpie_d = csr_write_data[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = csr_write_data & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = csr_write_data & ~32'h3;
        CSR_MSCRATCH: mscratch_d = csr_write_data;
        CSR_MEPC:     mepc_d     = csr_write_data & ~32'h3;
        CSR_MCAUSE:   mcause_d   = csr_write_data;
        default: ;
      endcase
    end

    case (ev)
      EV_IRQ, EV_ECALL, EV_EBREAK: begin
        mepc_d    = pc_ex & ~32'h3;
        st_mpie_d = st_mie_q;
        st_mie_d  = 1'b0;
        if (ev == EV_IRQ)        mcause_d = interrupt_cause;
        else if (ev == EV_ECALL) mcause_d = CAUSE_ECALL_M;
        else                     mcause_d = CAUSE_BREAKPOINT;
      end
      EV_MRET: begin
        st_mie_d  = st_mpie_q;
        st_mpie_d = 1'b1;
      end
      default: ;
    endcase
  end

  // CSR and trap-state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= 32'd0;
      mip_q      <= 32'd0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef ZICNTR_EN
  logic [63:0] mcycle_cnt;
  logic [63:0] minstret_cnt;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (csr_write_enable && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (csr_write_enable && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (csr_write_data),
    .count_o (mcycle_cnt)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (instr_retired),
    .wr_lo_i (csr_write_enable && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (csr_write_enable && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (csr_write_data),
    .count_o (minstret_cnt)
  );
`else
  logic unused_instr_retired;
  assign unused_instr_retired = instr_retired;
`endif

  // Combinational read mux; unimplemented or non-read requests return 0
  always_comb begin
    csr_read_data = 32'd0;
    csr_valid     = 1'b0;
    if (csr_read_enable) begin
      csr_valid = 1'b1;
      case (csr_addr)
        CSR_MSTATUS:  csr_read_data = mstatus_rd;
        CSR_MISA:     csr_read_data = MISA_VALUE;
        CSR_MIE:      csr_read_data = mie_q;
        CSR_MTVEC:    csr_read_data = mtvec_q;
        CSR_MSCRATCH: csr_read_data = mscratch_q;
        CSR_MEPC:     csr_read_data = mepc_q;
        CSR_MCAUSE:   csr_read_data = mcause_q;
        CSR_MIP:      csr_read_data = mip_q;
        CSR_MHARTID:  csr_read_data = HART_ID;
`ifdef ZICNTR_EN
        CSR_MCYCLE,   CSR_CYCLE:    csr_read_data = mcycle_cnt[31:0];
        CSR_MCYCLEH,  CSR_CYCLEH:   csr_read_data = mcycle_cnt[63:32];
        CSR_MINSTRET, CSR_INSTRET:  csr_read_data = minstret_cnt[31:0];
        CSR_MINSTRETH,CSR_INSTRETH: csr_read_data = minstret_cnt[63:32];
`endif
        default:      csr_valid = 1'b0;
      endcase
    end
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file. Expected read results are queued when a
// read is driven and popped when the combinational response is sampled.
// Counter checks follow ZICNTR_EN, matching the build of the design.
module tb_csr_file;

  localparam logic [31:0] P_MTVEC = 32'h0000_1003;
  localparam logic [31:0] P_HART  = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic        csr_read_enable, csr_write_enable;
  logic [31:0] csr_write_data, csr_read_data;
  logic        csr_valid;
  logic [31:0] pc_ex;
  logic        interrupt_taken, ecall_exception, ebreak_exception, mret_instruction;
  logic        instr_retired, ext_irq, timer_irq, sw_irq;
  logic        interrupt_pending;
  logic [31:0] interrupt_cause, mtvec, mepc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        exp_v_q[$];
  logic [31:0] rd_data;
  logic        rd_valid;

  csr_file #(.MTVEC_RESET(P_MTVEC), .HART_ID(P_HART)) dut (
    .clk(clk), .rst(rst),
    .csr_addr(csr_addr), .csr_read_enable(csr_read_enable),
    .csr_write_enable(csr_write_enable), .csr_write_data(csr_write_data),
    .csr_read_data(csr_read_data), .csr_valid(csr_valid),
    .pc_ex(pc_ex), .interrupt_taken(interrupt_taken),
    .ecall_exception(ecall_exception), .ebreak_exception(ebreak_exception),
    .mret_instruction(mret_instruction), .instr_retired(instr_retired),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .interrupt_pending(interrupt_pending), .interrupt_cause(interrupt_cause),
    .mtvec(mtvec), .mepc(mepc)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr         = a;
    csr_write_data   = d;
    csr_write_enable = 1'b1;
    tick();
    csr_write_enable = 1'b0;
  endtask

  // Queue the expected response, present the read, sample it mid-cycle
  task automatic drive_read(input logic [11:0] a, input logic [31:0] e, input logic ev);
    exp_q.push_back(e);
    exp_v_q.push_back(ev);
    csr_addr        = a;
    csr_read_enable = 1'b1;
    #1;
    rd_data         = csr_read_data;
    rd_valid        = csr_valid;
    csr_read_enable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] a[5];
    logic [31:0] d[5];
    logic        v[5];
    logic [31:0] e;
    logic        ev;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (interrupt_pending !== 1'b0 || interrupt_cause !== 32'd0) begin
      errors++;
      $display("FAIL reset_irq got %b/%h exp 0/0", interrupt_pending, interrupt_cause);
    end
    checks++;
    if (mtvec !== 32'h0000_1000 || mepc !== 32'd0) begin
      errors++;
      $display("FAIL reset_ports got mtvec %h mepc %h exp 00001000/0", mtvec, mepc);
    end
    a = '{12'h300, 12'h301, 12'hF14, 12'h7C0, 12'h305};
    d = '{32'h0000_1800, 32'h4000_0100, P_HART, 32'd0, 32'h0000_1000};
    v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_read(a[i], d[i], v[i]);
      e  = exp_q.pop_front();
      ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL reset_rd_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
    // No read request: data and valid must stay low
    csr_addr = 12'h300;
    #1;
    checks++;
    if (csr_read_data !== 32'd0 || csr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rd got %h/%b exp 0/0", csr_read_data, csr_valid);
    end
  endtask

  task automatic test_write();
    logic [11:0] a[5];
    logic [31:0] d[5];
    logic [31:0] e;
    logic        ev;
    csr_wr(12'h305, 32'h0000_0103);
    csr_wr(12'h301, 32'h0000_0000);
    csr_wr(12'h340, 32'hDEAD_BEEF);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_wr(12'h304, 32'hFFFF_FFFF);
    a = '{12'h305, 12'h301, 12'h340, 12'h300, 12'h304};
    d = '{32'h0000_0100, 32'h4000_0100, 32'hDEAD_BEEF, 32'h0000_1888, 32'h0000_0888};
    for (int i = 0; i < 5; i++) begin
      drive_read(a[i], d[i], 1'b1);
      e  = exp_q.pop_front();
      ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL wr_rd_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
    checks++;
    if (mtvec !== 32'h0000_0100) begin
      errors++;
      $display("FAIL mtvec_port got %h exp 00000100", mtvec);
    end
    csr_wr(12'h300, 32'h0);
    csr_wr(12'h304, 32'h0);
  endtask

  task automatic test_interrupt();
    logic [11:0] a[3];
    logic [31:0] d[3];
    logic [31:0] e;
    logic        ev;
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    ext_irq = 1'b1;
    #1;
    checks++;
    if (interrupt_pending !== 1'b0) begin
      errors++;
      $display("FAIL irq_sync got %b exp 0", interrupt_pending);
    end
    tick();
    checks++;
    if (interrupt_pending !== 1'b1 || interrupt_cause !== 32'h8000_000B) begin
      errors++;
      $display("FAIL irq_pend got %b/%h exp 1/8000000b", interrupt_pending, interrupt_cause);
    end
    interrupt_taken = 1'b1;
    pc_ex           = 32'h0000_0202;
    tick();
    interrupt_taken = 1'b0;
    checks++;
    if (mepc !== 32'h0000_0200 || interrupt_pending !== 1'b0) begin
      errors++;
      $display("FAIL irq_entry got mepc %h pend %b exp 00000200/0", mepc, interrupt_pending);
    end
    a = '{12'h342, 12'h300, 12'h344};
    d = '{32'h8000_000B, 32'h0000_1880, 32'h0000_0800};
    for (int i = 0; i < 3; i++) begin
      drive_read(a[i], d[i], 1'b1);
      e  = exp_q.pop_front();
      ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL irq_rd_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
    ext_irq = 1'b0;
    tick();
    csr_wr(12'h304, 32'h0);
  endtask

  task automatic test_ecall_mret();
    logic [31:0] e;
    logic        ev;
    csr_wr(12'h300, 32'h0000_0008);   // MIE=1, MPIE=0
    ecall_exception = 1'b1;
    pc_ex           = 32'h0000_0104;
    tick();
    ecall_exception = 1'b0;
    drive_read(12'h342, 32'd11, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e || mepc !== 32'h0000_0104) begin
      errors++;
      $display("FAIL ecall got mcause %h mepc %h exp %h/00000104", rd_data, mepc, e);
    end
    drive_read(12'h300, 32'h0000_1880, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL ecall_mstatus got %h exp %h", rd_data, e);
    end
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    drive_read(12'h300, 32'h0000_1888, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e || mepc !== 32'h0000_0104) begin
      errors++;
      $display("FAIL mret got mstatus %h mepc %h exp %h/00000104", rd_data, mepc, e);
    end
    // ECALL and a write to mepc together: the trap wins
    ecall_exception  = 1'b1;
    csr_addr         = 12'h341;
    csr_write_data   = 32'h0000_0999;
    csr_write_enable = 1'b1;
    tick();
    ecall_exception  = 1'b0;
    csr_write_enable = 1'b0;
    checks++;
    if (mepc !== 32'h0000_0104) begin
      errors++;
      $display("FAIL ecall_vs_wr got %h exp 00000104", mepc);
    end
    // ECALL beats EBREAK; a write to an unrelated CSR still commits
    ecall_exception  = 1'b1;
    ebreak_exception = 1'b1;
    pc_ex            = 32'h0000_0108;
    csr_addr         = 12'h340;
    csr_write_data   = 32'h0000_0055;
    csr_write_enable = 1'b1;
    tick();
    ecall_exception  = 1'b0;
    ebreak_exception = 1'b0;
    csr_write_enable = 1'b0;
    drive_read(12'h342, 32'd11, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e || mepc !== 32'h0000_0108) begin
      errors++;
      $display("FAIL ecall_prio got mcause %h mepc %h exp %h/00000108", rd_data, mepc, e);
    end
    drive_read(12'h340, 32'h0000_0055, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL side_wr got %h exp %h", rd_data, e);
    end
    // EBREAK alone overrides a write to mcause
    ebreak_exception = 1'b1;
    pc_ex            = 32'h0000_010C;
    csr_addr         = 12'h342;
    csr_write_data   = 32'h0000_0007;
    csr_write_enable = 1'b1;
    tick();
    ebreak_exception = 1'b0;
    csr_write_enable = 1'b0;
    drive_read(12'h342, 32'd3, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e || mepc !== 32'h0000_010C) begin
      errors++;
      $display("FAIL ebreak got mcause %h mepc %h exp %h/0000010c", rd_data, mepc, e);
    end
    // MRET leaves mepc alone, so a simultaneous mepc write commits
    mret_instruction = 1'b1;
    csr_addr         = 12'h341;
    csr_write_data   = 32'h0000_0998;
    csr_write_enable = 1'b1;
    tick();
    mret_instruction = 1'b0;
    csr_write_enable = 1'b0;
    drive_read(12'h300, 32'h0000_1880, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e || mepc !== 32'h0000_0998) begin
      errors++;
      $display("FAIL mret_wr got mstatus %h mepc %h exp %h/00000998", rd_data, mepc, e);
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp_cause[4];
    logic        exp_pend[4];
    csr_wr(12'h304, 32'h0000_0888);
    csr_wr(12'h300, 32'h0000_0008);
    exp_cause = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007, 32'd0};
    exp_pend  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ext_irq = 1'b1; timer_irq = 1'b1; sw_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (interrupt_pending !== exp_pend[i] || interrupt_cause !== exp_cause[i]) begin
        errors++;
        $display("FAIL prio_%0d got %b/%h exp %b/%h", i, interrupt_pending,
                 interrupt_cause, exp_pend[i], exp_cause[i]);
      end
      if (i == 0) ext_irq = 1'b0;
      if (i == 1) sw_irq = 1'b0;
      if (i == 2) timer_irq = 1'b0;
    end
    // Sources enabled but MIE clear: nothing pending, cause 0
    timer_irq = 1'b1;
    csr_wr(12'h300, 32'h0);
    tick();
    checks++;
    if (interrupt_pending !== 1'b0 || interrupt_cause !== 32'd0) begin
      errors++;
      $display("FAIL prio_masked got %b/%h exp 0/0", interrupt_pending, interrupt_cause);
    end
    timer_irq = 1'b0;
    tick();
  endtask

  task automatic test_counters();
    logic [31:0] e;
    logic        ev;
`ifdef ZICNTR_EN
    logic [11:0] a[3];
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'hFFFF_FFFF);   // low half holds on this edge
    tick();                            // wraps to zero
    a = '{12'hB00, 12'hB80, 12'hC80};
    for (int i = 0; i < 3; i++) begin
      drive_read(a[i], 32'd0, 1'b1);
      e = exp_q.pop_front(); ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL wrap_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
    csr_wr(12'hB00, 32'd5);
    drive_read(12'hB00, 32'd5, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL mcycle_wr got %h exp %h", rd_data, e);
    end
    csr_wr(12'hC00, 32'h0000_1234);   // alias is read-only; count just advances
    drive_read(12'hC00, 32'd6, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL alias_ro got %h exp %h", rd_data, e);
    end
    instr_retired = 1'b1;
    tick(); tick(); tick();
    instr_retired = 1'b0;
    tick();
    a = '{12'hB02, 12'hC02, 12'hB82};
    for (int i = 0; i < 3; i++) begin
      drive_read(a[i], (i == 2) ? 32'd0 : 32'd3, 1'b1);
      e = exp_q.pop_front(); ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL instret_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
`else
    logic [11:0] a[4];
    instr_retired = 1'b1;
    csr_wr(12'hB00, 32'h0000_0077);
    instr_retired = 1'b0;
    a = '{12'hB00, 12'hB80, 12'hC00, 12'hB02};
    for (int i = 0; i < 4; i++) begin
      drive_read(a[i], 32'd0, 1'b0);
      e = exp_q.pop_front(); ev = exp_v_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== ev) begin
        errors++;
        $display("FAIL nocnt_%h got %h/%b exp %h/%b", a[i], rd_data, rd_valid, e, ev);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    logic        ev;
    csr_wr(12'h340, 32'hA5A5_A5A5);
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    ext_irq = 1'b1;
    tick();
    checks++;
    if (interrupt_pending !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %b exp 1", interrupt_pending);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (interrupt_pending !== 1'b0 || mtvec !== 32'h0000_1000 || mepc !== 32'd0) begin
      errors++;
      $display("FAIL async_rst got pend %b mtvec %h mepc %h exp 0/00001000/0",
               interrupt_pending, mtvec, mepc);
    end
    drive_read(12'h340, 32'd0, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL rst_mscratch got %h exp %h", rd_data, e);
    end
`ifdef ZICNTR_EN
    drive_read(12'hB02, 32'd0, 1'b1);
    e = exp_q.pop_front(); ev = exp_v_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL rst_minstret got %h exp %h", rd_data, e);
    end
`endif
    ext_irq = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    csr_addr = 12'h0; csr_read_enable = 1'b0; csr_write_enable = 1'b0;
    csr_write_data = 32'h0; pc_ex = 32'h0;
    interrupt_taken = 1'b0; ecall_exception = 1'b0; ebreak_exception = 1'b0;
    mret_instruction = 1'b0; instr_retired = 1'b0;
    ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
    rd_data = 32'h0; rd_valid = 1'b0;
    test_reset();
    test_write();
    test_interrupt();
    test_ecall_mret();
    test_priority();
    test_counters();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
